// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the BIOS
// loader (exclusive owner before boot) and the CPU fetch/data ports
// (round-robin arbitrated after boot). A one-cycle DRAIN separates the owners.
// A registered return tag routes the read data that arrives one cycle later
// back to the requester that issued the read.
// Optional feature: define MEM_ARB_STATS_EN to add saturating grant/conflict
// counters on three extra 32-bit output ports.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_booted,
    // BIOS side
    input  logic                  i_bios_read_req,
    input  logic                  i_bios_write_enable,
    input  logic [3:0]            i_bios_byte_enable,
    input  logic [ADDR_WIDTH:0]   i_bios_addr,
    input  logic [DATA_WIDTH:0]   i_bios_write_data,
    output logic [DATA_WIDTH:0]   o_bios_read_data,
    output logic                  o_bios_rvalid,
    // CPU instruction fetch
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH:0]   i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_WIDTH:0]   o_if_rdata,
    // CPU data
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [3:0]            i_d_be,
    input  logic [ADDR_WIDTH:0]   i_d_addr,
    input  logic [DATA_WIDTH:0]   i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_WIDTH:0]   o_d_rdata,
    // RAM macro
    output logic                  o_ram_en,
    output logic [3:0]            o_ram_we,
    output logic [ADDR_WIDTH:0]   o_ram_addr,
    output logic [DATA_WIDTH:0]   o_ram_wdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]           o_stat_if_grants,
    output logic [31:0]           o_stat_d_grants,
    output logic [31:0]           o_stat_conflicts,
`endif
    input  logic [DATA_WIDTH:0]   i_ram_rdata
);

    typedef enum logic [1:0] {
        OWN_BIOS = 2'd0,
        DRAIN    = 2'd1,
        OWN_CPU  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_BIOS = 2'd1,
        TAG_IF   = 2'd2,
        TAG_D    = 2'd3
    } tag_t;

    state_t state_q, state_d;
    tag_t   tag_q, tag_d;
    // 1 = data port wins the next contested cycle, 0 = fetch port wins
    logic   rr_d_first_q, rr_d_first_d;
    logic   both_req_s;

    assign both_req_s = i_if_req & i_d_req;

    // State, round-robin pointer and return tag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OWN_BIOS;
            tag_q        <= TAG_NONE;
            rr_d_first_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            rr_d_first_q <= rr_d_first_d;
        end
    end

    // Ownership sequencing; DRAIN resolves its exit from the current boot flag
    always_comb begin
        state_d = state_q;
        case (state_q)
            OWN_BIOS: begin
                if (i_booted) state_d = DRAIN;
                else          state_d = OWN_BIOS;
            end
            DRAIN: begin
                if (i_booted) state_d = OWN_CPU;
                else          state_d = OWN_BIOS;
            end
            OWN_CPU: begin
                if (!i_booted) state_d = DRAIN;
                else           state_d = OWN_CPU;
            end
            default: state_d = OWN_BIOS;
        endcase
    end

    // Grants, RAM controls and the tag for the read issued this cycle
    always_comb begin
        o_if_gnt     = 1'b0;
        o_d_gnt      = 1'b0;
        o_ram_en     = 1'b0;
        o_ram_we     = 4'b0000;
        o_ram_addr   = '0;
        o_ram_wdata  = '0;
        tag_d        = TAG_NONE;
        rr_d_first_d = rr_d_first_q;
        case (state_q)
            OWN_BIOS: begin
                // A write wins over a simultaneous read; the read is dropped
                if (i_bios_write_enable) begin
                    o_ram_en    = 1'b1;
                    o_ram_we    = i_bios_byte_enable;
                    o_ram_addr  = i_bios_addr;
                    o_ram_wdata = i_bios_write_data;
                end else if (i_bios_read_req) begin
                    o_ram_en   = 1'b1;
                    o_ram_addr = i_bios_addr;
                    tag_d      = TAG_BIOS;
                end else begin
                    o_ram_en = 1'b0;
                end
            end
            OWN_CPU: begin
                if (both_req_s) begin
                    o_d_gnt      = rr_d_first_q;
                    o_if_gnt     = ~rr_d_first_q;
                    rr_d_first_d = ~rr_d_first_q;
                end else begin
                    o_d_gnt  = i_d_req;
                    o_if_gnt = i_if_req;
                end
                if (o_d_gnt) begin
                    o_ram_en    = 1'b1;
                    o_ram_addr  = i_d_addr;
                    o_ram_wdata = i_d_wdata;
                    if (i_d_we) begin
                        o_ram_we = i_d_be;
                    end else begin
                        tag_d = TAG_D;
                    end
                end else if (o_if_gnt) begin
                    o_ram_en   = 1'b1;
                    o_ram_addr = i_if_addr;
                    tag_d      = TAG_IF;
                end else begin
                    o_ram_en = 1'b0;
                end
            end
            default: begin
                // DRAIN: no access, no grant; the pending tag still returns
                o_ram_en = 1'b0;
            end
        endcase
    end

    assign o_bios_rvalid    = (tag_q == TAG_BIOS);
    assign o_if_rvalid      = (tag_q == TAG_IF);
    assign o_d_rvalid       = (tag_q == TAG_D);
    assign o_bios_read_data = i_ram_rdata;
    assign o_if_rdata       = i_ram_rdata;
    assign o_d_rdata        = i_ram_rdata;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_if_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_cf_q, stat_cf_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) return v;
        else                    return v + 32'd1;
    endfunction

    // Next values of the saturating statistics counters
    always_comb begin
        stat_if_d = stat_if_q;
        stat_d_d  = stat_d_q;
        stat_cf_d = stat_cf_q;
        if (o_if_gnt) stat_if_d = sat_inc(stat_if_q);
        else          stat_if_d = stat_if_q;
        if (o_d_gnt)  stat_d_d = sat_inc(stat_d_q);
        else          stat_d_d = stat_d_q;
        if ((state_q == OWN_CPU) && both_req_s) stat_cf_d = sat_inc(stat_cf_q);
        else                                    stat_cf_d = stat_cf_q;
    end

    // Statistics counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_q <= 32'd0;
            stat_d_q  <= 32'd0;
            stat_cf_q <= 32'd0;
        end else begin
            stat_if_q <= stat_if_d;
            stat_d_q  <= stat_d_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign o_stat_if_grants = stat_if_q;
    assign o_stat_d_grants  = stat_d_q;
    assign o_stat_conflicts = stat_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a cycle-level ownership/arbitration model and a
// shadow memory kept inside the bench.
module tb_mem_port_arbiter;

    localparam int K_NONE = 0, K_BIOS = 1, K_IF = 2, K_D = 3;
    localparam int M_BIOS = 0, M_DRAIN = 1, M_CPU = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_booted;
    logic        i_bios_read_req, i_bios_write_enable;
    logic [3:0]  i_bios_byte_enable;
    logic [31:0] i_bios_addr, i_bios_write_data, o_bios_read_data;
    logic        o_bios_rvalid;
    logic        i_if_req;
    logic [31:0] i_if_addr, o_if_rdata;
    logic        o_if_gnt, o_if_rvalid;
    logic        i_d_req, i_d_we;
    logic [3:0]  i_d_be;
    logic [31:0] i_d_addr, i_d_wdata, o_d_rdata;
    logic        o_d_gnt, o_d_rvalid;
    logic        o_ram_en;
    logic [3:0]  o_ram_we;
    logic [31:0] o_ram_addr, o_ram_wdata;
    logic [31:0] ram_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] o_stat_if_grants, o_stat_d_grants, o_stat_conflicts;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
        .clk(clk), .rst(rst), .i_booted(i_booted),
        .i_bios_read_req(i_bios_read_req), .i_bios_write_enable(i_bios_write_enable),
        .i_bios_byte_enable(i_bios_byte_enable), .i_bios_addr(i_bios_addr),
        .i_bios_write_data(i_bios_write_data), .o_bios_read_data(o_bios_read_data),
        .o_bios_rvalid(o_bios_rvalid),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid),
        .o_d_rdata(o_d_rdata),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata),
`ifdef MEM_ARB_STATS_EN
        .o_stat_if_grants(o_stat_if_grants), .o_stat_d_grants(o_stat_d_grants),
        .o_stat_conflicts(o_stat_conflicts),
`endif
        .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro stand-in: 64 words, byte-lane writes, data one cycle after en
    logic [31:0] ram_mem [0:63];
    always @(posedge clk) begin
        if (o_ram_en) begin
            for (int b = 0; b < 4; b++)
                if (o_ram_we[b]) ram_mem[o_ram_addr[5:0]][b*8 +: 8] <= o_ram_wdata[b*8 +: 8];
            ram_rdata <= ram_mem[o_ram_addr[5:0]];
        end
    end

    // Reference model state
    logic [31:0] exp_mem [0:63];
    int          mdl_mode;
    bit          mdl_prefer_d;
    int          pend_kind;
    logic [31:0] pend_data;
    bit          last_if_gnt, last_d_gnt;
    int unsigned mdl_if_cnt, mdl_d_cnt, mdl_cf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_mode     = M_BIOS;
        mdl_prefer_d = 1'b1;
        pend_kind    = K_NONE;
        pend_data    = 32'd0;
        last_if_gnt  = 1'b0;
        last_d_gnt   = 1'b0;
        mdl_if_cnt   = 0;
        mdl_d_cnt    = 0;
        mdl_cf_cnt   = 0;
    endtask

    // Called at a falling edge with inputs driven; checks, advances the model,
    // and returns at the next falling edge.
    task automatic run_cycle();
        bit          eg_if, eg_d, een;
        logic [3:0]  ewe;
        logic [31:0] eaddr, ewdata;
        int          rkind;
        #1;
        check_val("bios_rvalid", o_bios_rvalid, pend_kind == K_BIOS);
        check_val("if_rvalid", o_if_rvalid, pend_kind == K_IF);
        check_val("d_rvalid", o_d_rvalid, pend_kind == K_D);
        if (pend_kind == K_BIOS) check_val("bios_rdata", o_bios_read_data, pend_data);
        if (pend_kind == K_IF)   check_val("if_rdata", o_if_rdata, pend_data);
        if (pend_kind == K_D)    check_val("d_rdata", o_d_rdata, pend_data);

        eg_if = 1'b0; eg_d = 1'b0; een = 1'b0; ewe = 4'b0000;
        eaddr = 32'd0; ewdata = 32'd0; rkind = K_NONE;
        if (mdl_mode == M_BIOS) begin
            if (i_bios_write_enable) begin
                een = 1'b1; ewe = i_bios_byte_enable; eaddr = i_bios_addr; ewdata = i_bios_write_data;
            end else if (i_bios_read_req) begin
                een = 1'b1; eaddr = i_bios_addr; rkind = K_BIOS;
            end
        end else if (mdl_mode == M_CPU) begin
            eg_d  = i_d_req && (!i_if_req || mdl_prefer_d);
            eg_if = i_if_req && !eg_d;
            if (eg_d) begin
                een = 1'b1; eaddr = i_d_addr; ewdata = i_d_wdata;
                if (i_d_we) ewe = i_d_be;
                else        rkind = K_D;
            end else if (eg_if) begin
                een = 1'b1; eaddr = i_if_addr; rkind = K_IF;
            end
        end

        check_val("if_gnt", o_if_gnt, eg_if);
        check_val("d_gnt", o_d_gnt, eg_d);
        check_val("ram_en", o_ram_en, een);
        check_val("ram_we", o_ram_we, ewe);
        if (een) check_val("ram_addr", o_ram_addr, eaddr);
        if (ewe != 4'b0000) check_val("ram_wdata", o_ram_wdata, ewdata);

        // Model advance for the coming rising edge
        pend_kind = rkind;
        if (rkind != K_NONE) pend_data = exp_mem[eaddr[5:0]];
        for (int b = 0; b < 4; b++)
            if (ewe[b]) exp_mem[eaddr[5:0]][b*8 +: 8] = ewdata[b*8 +: 8];
        if (mdl_mode == M_CPU && i_if_req && i_d_req) begin
            mdl_prefer_d = !mdl_prefer_d;
            mdl_cf_cnt++;
        end
        if (eg_if) mdl_if_cnt++;
        if (eg_d)  mdl_d_cnt++;
        last_if_gnt = eg_if;
        last_d_gnt  = eg_d;
        case (mdl_mode)
            M_BIOS:  mdl_mode = i_booted ? M_DRAIN : M_BIOS;
            M_DRAIN: mdl_mode = i_booted ? M_CPU : M_BIOS;
            default: mdl_mode = i_booted ? M_CPU : M_DRAIN;
        endcase
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_bios_read_req = 1'b0; i_bios_write_enable = 1'b0; i_bios_byte_enable = 4'h0;
        i_bios_addr = 32'd0; i_bios_write_data = 32'd0;
        i_if_req = 1'b0; i_if_addr = 32'd0;
        i_d_req = 1'b0; i_d_we = 1'b0; i_d_be = 4'h0; i_d_addr = 32'd0; i_d_wdata = 32'd0;
    endtask

    // Asserted at a falling edge; outputs must clear immediately
    task automatic apply_reset();
        rst = 1'b1;
        i_booted = 1'b0;
        clear_inputs();
        #1;
        check_val("rst_bios_rvalid", o_bios_rvalid, 1'b0);
        check_val("rst_if_rvalid", o_if_rvalid, 1'b0);
        check_val("rst_d_rvalid", o_d_rvalid, 1'b0);
        check_val("rst_if_gnt", o_if_gnt, 1'b0);
        check_val("rst_d_gnt", o_d_gnt, 1'b0);
        check_val("rst_ram_en", o_ram_en, 1'b0);
        check_val("rst_ram_we", o_ram_we, 4'b0000);
`ifdef MEM_ARB_STATS_EN
        check_val("rst_stat_cf", o_stat_conflicts, 32'd0);
        check_val("rst_stat_if", o_stat_if_grants, 32'd0);
        check_val("rst_stat_d", o_stat_d_grants, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        if (($urandom % 50) == 0) i_booted = ~i_booted;
        i_bios_write_enable = ($urandom % 4) == 0;
        i_bios_read_req     = ($urandom % 3) == 0;
        i_bios_byte_enable  = 4'($urandom);
        i_bios_addr         = $urandom_range(0, 63);
        i_bios_write_data   = $urandom;
        if (!(i_if_req && !last_if_gnt)) begin
            i_if_req  = ($urandom % 3) != 0;
            i_if_addr = $urandom_range(0, 63);
        end
        if (!(i_d_req && !last_d_gnt)) begin
            i_d_req   = ($urandom % 3) != 0;
            i_d_we    = ($urandom % 2) == 0;
            i_d_be    = 4'($urandom);
            i_d_addr  = $urandom_range(0, 63);
            i_d_wdata = $urandom;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 32'd0;
            exp_mem[i] = 32'd0;
        end
        ram_rdata = 32'd0;
        rst = 1'b0;
        i_booted = 1'b0;
        clear_inputs();
        #2;
        apply_reset();

        // BIOS write then read back of 0x10
        i_bios_write_enable = 1'b1; i_bios_byte_enable = 4'hF;
        i_bios_addr = 32'h10; i_bios_write_data = 32'hDEAD_BEEF;
        run_cycle();
        i_bios_write_enable = 1'b0; i_bios_read_req = 1'b1;
        i_if_req = 1'b1; i_d_req = 1'b1;
        run_cycle();
        i_bios_read_req = 1'b0; i_d_req = 1'b0;
        #1;
        check_val("bios_dir_rdata", o_bios_read_data, 32'hDEAD_BEEF);
        #1;

        // Boot with a fetch request held: BIOS cycle, DRAIN, then grant
        i_booted = 1'b1; i_if_addr = 32'h5;
        run_cycle();
        run_cycle();
        #1;
        check_val("post_drain_if_gnt", o_if_gnt, 1'b1);
        #1;
        run_cycle();

        // Contested window with BIOS strobes that must be ignored
        i_if_req = 1'b1; i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h10;
        i_bios_write_enable = 1'b1; i_bios_read_req = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle();
        clear_inputs();
        run_cycle();

        // Single byte-lane write and read back
        i_d_req = 1'b1; i_d_we = 1'b1; i_d_be = 4'b0100;
        i_d_addr = 32'h20; i_d_wdata = 32'hAABB_CCDD;
        run_cycle();
        i_d_we = 1'b0;
        run_cycle();
        i_d_req = 1'b0;
        #1;
        check_val("lane2_rdata", o_d_rdata, 32'h00BB_0000);
        #1;
        run_cycle();

        // Fetch grant followed immediately by reset
        i_if_req = 1'b1; i_if_addr = 32'h10;
        run_cycle();
        apply_reset();

`ifdef MEM_ARB_STATS_EN
        // Ten contested cycles from a fresh reset
        i_booted = 1'b1;
        run_cycle();
        run_cycle();
        i_if_req = 1'b1; i_d_req = 1'b1;
        for (int i = 0; i < 10; i++) run_cycle();
        clear_inputs();
        #1;
        check_val("stat_conflicts10", o_stat_conflicts, 32'd10);
        check_val("stat_if5", o_stat_if_grants, 32'd5);
        check_val("stat_d5", o_stat_d_grants, 32'd5);
        #1;
        run_cycle();
`endif

        // Randomized traffic with occasional boot toggles and resets
        for (int c = 0; c < 3000; c++) begin
            if (($urandom % 400) == 0) begin
                apply_reset();
            end else begin
                randomize_inputs();
                run_cycle();
            end
        end

`ifdef MEM_ARB_STATS_EN
        #1;
        check_val("stat_if_final", o_stat_if_grants, mdl_if_cnt);
        check_val("stat_d_final", o_stat_d_grants, mdl_d_cnt);
        check_val("stat_cf_final", o_stat_conflicts, mdl_cf_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
